// File: rtl/bbox_test_sequencer.sv
// ---------------------------------------------------------------------------
// bbox_test_sequencer
//
// Self-checking stimulus sequencer for a passthrough or pipelined black-box
// datapath. One run drives NUM_VECTORS pseudo-random words from a 16-bit
// Galois LFSR into the DUT. Each DUT response is compared with the word
// expected LATENCY cycles later. Mismatches are counted, and done/pass are
// reported when the run ends.
//
// Optional feature macro: BBOX_SEQ_ERRCAP_EN
//   defined   : the first mismatch of each run is captured into
//               err_idx/err_exp/err_got
//   undefined : err_idx/err_exp/err_got are tied to zero
//
// Parameters
//   WIDTH        DUT data width (1..16)
//   NUM_VECTORS  vectors per run (1..65535)
//   LATENCY      DUT input->output delay in cycles (0..7, 0 = combinational)
//   SEED         nonzero LFSR seed, reloaded on every accepted start
//   ERRW         err_count width
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   start      in   pulse, begins a run when not busy
//   abort      in   level, cancels a run in progress
//   dut_in     out  stimulus word to the DUT (zero outside DRIVE)
//   dut_out    in   DUT response
//   busy       out  run in progress (DRIVE or DRAIN)
//   done       out  run completed normally, held until the next accepted start
//   pass       out  done with zero mismatches
//   err_count  out  mismatches in this run, saturating
//   err_idx    out  vector index of the first mismatch
//   err_exp    out  expected word of the first mismatch
//   err_got    out  DUT word of the first mismatch
// ---------------------------------------------------------------------------
module bbox_test_sequencer #(
    parameter int          WIDTH       = 1,
    parameter int          NUM_VECTORS = 16,
    parameter int          LATENCY     = 0,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          ERRW        = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] dut_in,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERRW-1:0]  err_count,
    output logic [15:0]      err_idx,
    output logic [WIDTH-1:0] err_exp,
    output logic [WIDTH-1:0] err_got
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right shift).
    localparam logic [15:0] TAPS       = 16'hB400;
    localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
    localparam logic [2:0]  DRAIN_INIT = 3'(LATENCY - 1);

    logic [1:0]       state;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_next;
    logic [15:0]      idx;
    logic [2:0]       drain_cnt;

    logic             driving;
    logic             kill;
    logic             accept;
    logic             cmp_valid;
    logic [WIDTH-1:0] cmp_exp;
    logic             cmp_en;
    logic             mismatch;

    // -----------------------------------------------------------------------
    // Control decode
    // -----------------------------------------------------------------------
    assign driving = (state == S_DRIVE);
    assign busy    = (state == S_DRIVE) || (state == S_DRAIN);
    assign kill    = abort && busy;
    // abort has priority over start even when idle or done
    assign accept  = start && !abort && ((state == S_IDLE) || (state == S_DONE));
    assign dut_in  = driving ? lfsr[WIDTH-1:0] : '0;
    assign pass    = done && (err_count == '0);

    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]};
        if (lfsr[0]) begin
            lfsr_next = lfsr_next ^ TAPS;
        end
    end

    // -----------------------------------------------------------------------
    // Compare alignment: the valid flag and the expected word travel through
    // LATENCY stages next to the stimulus. The tail of that pipe therefore
    // lines up with the matching DUT response. At LATENCY 0 the drive cycle
    // itself is compared.
    // -----------------------------------------------------------------------
`ifdef BBOX_SEQ_ERRCAP_EN
    logic [15:0] cmp_idx;
`endif

    generate
        if (LATENCY == 0) begin : g_comb
            assign cmp_valid = driving;
            assign cmp_exp   = dut_in;
`ifdef BBOX_SEQ_ERRCAP_EN
            assign cmp_idx   = idx;
`endif
        end else begin : g_pipe
            logic [LATENCY-1:0] vpipe;
            logic [WIDTH-1:0]   epipe [LATENCY];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    vpipe <= '0;
                    for (int unsigned i = 0; i < LATENCY; i++) begin
                        epipe[i] <= '0;
                    end
                end else if (kill) begin
                    vpipe <= '0;
                    for (int unsigned i = 0; i < LATENCY; i++) begin
                        epipe[i] <= '0;
                    end
                end else begin
                    vpipe[0] <= driving;
                    epipe[0] <= dut_in;
                    for (int unsigned i = 1; i < LATENCY; i++) begin
                        vpipe[i] <= vpipe[i-1];
                        epipe[i] <= epipe[i-1];
                    end
                end
            end

            assign cmp_valid = vpipe[LATENCY-1];
            assign cmp_exp   = epipe[LATENCY-1];

`ifdef BBOX_SEQ_ERRCAP_EN
            // The index only matters where the valid flag is set, so it
            // follows the same shift without being cleared on abort.
            logic [15:0] ipipe [LATENCY];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int unsigned i = 0; i < LATENCY; i++) begin
                        ipipe[i] <= '0;
                    end
                end else begin
                    ipipe[0] <= idx;
                    for (int unsigned i = 1; i < LATENCY; i++) begin
                        ipipe[i] <= ipipe[i-1];
                    end
                end
            end

            assign cmp_idx = ipipe[LATENCY-1];
`endif
        end
    endgenerate

    // A compare that falls in the abort cycle is discarded, so err_count
    // holds the value it had before the abort.
    assign cmp_en   = cmp_valid && !kill;
    assign mismatch = (dut_out != cmp_exp);

    // -----------------------------------------------------------------------
    // Sequencer FSM, LFSR, vector index and mismatch counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            lfsr      <= SEED;
            idx       <= '0;
            drain_cnt <= '0;
            done      <= 1'b0;
            err_count <= '0;
        end else begin
            if (cmp_en && mismatch && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state     <= S_DRIVE;
                        lfsr      <= SEED;
                        idx       <= '0;
                        done      <= 1'b0;
                        err_count <= '0;
                    end
                end

                S_DRIVE: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        lfsr <= lfsr_next;
                        idx  <= idx + 16'd1;
                        if (idx == LAST_IDX) begin
                            if (LATENCY > 0) begin
                                state     <= S_DRAIN;
                                drain_cnt <= DRAIN_INIT;
                            end else begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                end

                S_DRAIN: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (drain_cnt == 3'd0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // First-mismatch capture
    // -----------------------------------------------------------------------
`ifdef BBOX_SEQ_ERRCAP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_idx <= '0;
            err_exp <= '0;
            err_got <= '0;
        end else if (accept) begin
            err_idx <= '0;
            err_exp <= '0;
            err_got <= '0;
        end else if (cmp_en && mismatch && (err_count == '0)) begin
            err_idx <= cmp_idx;
            err_exp <= cmp_exp;
            err_got <= dut_out;
        end
    end
`else
    assign err_idx = '0;
    assign err_exp = '0;
    assign err_got = '0;
`endif

endmodule

// File: tb/tb_bbox_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bbox_test_sequencer
//
// Bench for bbox_test_sequencer. Six sequencer instances are paired with
// small black-box models:
//   u0  ideal passthrough, WIDTH 8, LATENCY 0
//   u1  3-stage pipe,      WIDTH 8, LATENCY 3
//   u2  3-stage pipe,      WIDTH 8, LATENCY 2 (misaligned on purpose)
//   u3  bit0 stuck at 1,   WIDTH 1
//   u4  inverter,          WIDTH 4, 300 vectors
//   u5  4-stage pipe,      WIDTH 5, LATENCY 4, random bit flips and aborts
// Expected values come from an arithmetic model of the LFSR sequence and of
// each black box.
// ---------------------------------------------------------------------------
module tb_bbox_test_sequencer;

    localparam logic [15:0] SEED = 16'hACE1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [5:0] st = '0;
    logic [5:0] ab = '0;
    wire  [5:0] bz, dn, ps;
    wire  [7:0] ec [6];
    wire  [15:0] ei [6];
    wire  [15:0] din_w [6];
    wire  [15:0] ee [6];
    wire  [15:0] eg [6];

    int n_vec = 0;
    int n_err = 0;

    logic [4:0] flip5 = '0;
    logic [4:0] flips [64];

    // u0: ideal
    logic [7:0] d0_in, d0_out, x0, g0;
    assign d0_out = d0_in;
    bbox_test_sequencer #(.WIDTH(8), .NUM_VECTORS(16), .LATENCY(0), .SEED(SEED), .ERRW(8)) u0 (
        .clock(clock), .reset(reset), .start(st[0]), .abort(ab[0]), .dut_in(d0_in), .dut_out(d0_out),
        .busy(bz[0]), .done(dn[0]), .pass(ps[0]), .err_count(ec[0]), .err_idx(ei[0]),
        .err_exp(x0), .err_got(g0));
    assign din_w[0] = {8'h0, d0_in};
    assign ee[0] = {8'h0, x0};
    assign eg[0] = {8'h0, g0};

    // u1: 3-stage pipe, matched latency
    logic [7:0] d1_in, d1_out, x1, g1;
    logic [7:0] p1a = '0, p1b = '0, p1c = '0;
    always @(posedge clock) begin
        p1a <= d1_in;
        p1b <= p1a;
        p1c <= p1b;
    end
    assign d1_out = p1c;
    bbox_test_sequencer #(.WIDTH(8), .NUM_VECTORS(16), .LATENCY(3), .SEED(SEED), .ERRW(8)) u1 (
        .clock(clock), .reset(reset), .start(st[1]), .abort(ab[1]), .dut_in(d1_in), .dut_out(d1_out),
        .busy(bz[1]), .done(dn[1]), .pass(ps[1]), .err_count(ec[1]), .err_idx(ei[1]),
        .err_exp(x1), .err_got(g1));
    assign din_w[1] = {8'h0, d1_in};
    assign ee[1] = {8'h0, x1};
    assign eg[1] = {8'h0, g1};

    // u2: 3-stage pipe, sequencer set to latency 2
    logic [7:0] d2_in, d2_out, x2, g2;
    logic [7:0] p2a = '0, p2b = '0, p2c = '0;
    always @(posedge clock) begin
        p2a <= d2_in;
        p2b <= p2a;
        p2c <= p2b;
    end
    assign d2_out = p2c;
    bbox_test_sequencer #(.WIDTH(8), .NUM_VECTORS(16), .LATENCY(2), .SEED(SEED), .ERRW(8)) u2 (
        .clock(clock), .reset(reset), .start(st[2]), .abort(ab[2]), .dut_in(d2_in), .dut_out(d2_out),
        .busy(bz[2]), .done(dn[2]), .pass(ps[2]), .err_count(ec[2]), .err_idx(ei[2]),
        .err_exp(x2), .err_got(g2));
    assign din_w[2] = {8'h0, d2_in};
    assign ee[2] = {8'h0, x2};
    assign eg[2] = {8'h0, g2};

    // u3: bit0 stuck at 1
    logic d3_in, d3_out, x3, g3;
    assign d3_out = 1'b1;
    bbox_test_sequencer #(.WIDTH(1), .NUM_VECTORS(16), .LATENCY(0), .SEED(SEED), .ERRW(8)) u3 (
        .clock(clock), .reset(reset), .start(st[3]), .abort(ab[3]), .dut_in(d3_in), .dut_out(d3_out),
        .busy(bz[3]), .done(dn[3]), .pass(ps[3]), .err_count(ec[3]), .err_idx(ei[3]),
        .err_exp(x3), .err_got(g3));
    assign din_w[3] = {15'h0, d3_in};
    assign ee[3] = {15'h0, x3};
    assign eg[3] = {15'h0, g3};

    // u4: inverter, long run for saturation
    logic [3:0] d4_in, d4_out, x4, g4;
    assign d4_out = ~d4_in;
    bbox_test_sequencer #(.WIDTH(4), .NUM_VECTORS(300), .LATENCY(0), .SEED(SEED), .ERRW(8)) u4 (
        .clock(clock), .reset(reset), .start(st[4]), .abort(ab[4]), .dut_in(d4_in), .dut_out(d4_out),
        .busy(bz[4]), .done(dn[4]), .pass(ps[4]), .err_count(ec[4]), .err_idx(ei[4]),
        .err_exp(x4), .err_got(g4));
    assign din_w[4] = {12'h0, d4_in};
    assign ee[4] = {12'h0, x4};
    assign eg[4] = {12'h0, g4};

    // u5: 4-stage pipe with injected flips at its input
    logic [4:0] d5_in, d5_out, x5, g5;
    logic [4:0] r5a = '0, r5b = '0, r5c = '0, r5d = '0;
    always @(posedge clock) begin
        r5a <= d5_in ^ flip5;
        r5b <= r5a;
        r5c <= r5b;
        r5d <= r5c;
    end
    assign d5_out = r5d;
    bbox_test_sequencer #(.WIDTH(5), .NUM_VECTORS(40), .LATENCY(4), .SEED(SEED), .ERRW(8)) u5 (
        .clock(clock), .reset(reset), .start(st[5]), .abort(ab[5]), .dut_in(d5_in), .dut_out(d5_out),
        .busy(bz[5]), .done(dn[5]), .pass(ps[5]), .err_count(ec[5]), .err_idx(ei[5]),
        .err_exp(x5), .err_got(g5));
    assign din_w[5] = {11'h0, d5_in};
    assign ee[5] = {11'h0, x5};
    assign eg[5] = {11'h0, g5};

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        if (x[0]) return (x >> 1) ^ 16'hB400;
        return x >> 1;
    endfunction

    function automatic logic [15:0] stim(input int i, input int width);
        logic [15:0] l;
        l = SEED;
        for (int j = 0; j < i; j++) l = lfsr_step(l);
        return l & 16'((32'd1 << width) - 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_cap(input string tag, input int s, input logic [15:0] i,
                             input logic [15:0] e, input logic [15:0] g);
`ifdef BBOX_SEQ_ERRCAP_EN
        check({tag, "_idx"}, ei[s], i);
        check({tag, "_exp"}, ee[s], e);
        check({tag, "_got"}, eg[s], g);
`else
        check({tag, "_idx"}, ei[s], 16'h0);
        check({tag, "_exp"}, ee[s], 16'h0);
        check({tag, "_got"}, eg[s], 16'h0);
`endif
    endtask

    // Called just after a negedge. Pulses start and then follows the run
    // cycle by cycle, checking dut_in against the model sequence, until busy
    // drops or the cycle budget runs out.
    task automatic run_seq(input int s, input int width, input int nv, input int lat,
                           input int abort_at, input int restart_at, output int cyc);
        logic [15:0] l;
        logic [15:0] mask;
        int k;
        l = SEED;
        mask = 16'((32'd1 << width) - 1);
        cyc = 0;
        k = 0;
        st[s] = 1'b1;
        @(negedge clock);
        st[s] = 1'b0;
        while (bz[s] && k < nv + lat + 8) begin
            if (k < nv) begin
                check("dut_in", din_w[s], l & mask);
                l = lfsr_step(l);
            end else begin
                check("dut_in_drain", din_w[s], 16'h0);
            end
            flip5 = (s == 5 && k < nv) ? flips[k] : 5'h0;
            ab[s] = (k == abort_at);
            st[s] = (k == restart_at);
            cyc++;
            k++;
            @(negedge clock);
        end
        ab[s] = 1'b0;
        st[s] = 1'b0;
        flip5 = '0;
    endtask

    initial begin
        int c;
        int cnt;
        int first;
        int limit;
        int abort_at;
        logic [15:0] e;
        logic [15:0] g;

        // Reset state of every instance
        @(negedge clock);
        for (int s = 0; s < 6; s++) begin
            check("rst_busy", bz[s], 0);
            check("rst_done", dn[s], 0);
            check("rst_pass", ps[s], 0);
            check("rst_err", ec[s], 0);
            check("rst_din", din_w[s], 0);
            check_cap("rst_cap", s, 0, 0, 0);
        end
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // Test 1: ideal DUT
        run_seq(0, 8, 16, 0, -1, -1, c);
        check("t1_busy_cycles", c, 16);
        check("t1_done", dn[0], 1);
        check("t1_pass", ps[0], 1);
        check("t1_err", ec[0], 0);
        check_cap("t1_cap", 0, 0, 0, 0);
        repeat (3) @(negedge clock);
        check("t1_done_held", dn[0], 1);

        // Start while busy is ignored; start from DONE restarts at once
        run_seq(0, 8, 16, 0, -1, 5, c);
        check("t1b_busy_cycles", c, 16);
        check("t1b_pass", ps[0], 1);

        // Test 2: matched 3-stage pipe, then misaligned latency
        repeat (4) @(negedge clock);
        run_seq(1, 8, 16, 3, -1, -1, c);
        check("t2_busy_cycles", c, 19);
        check("t2_pass", ps[1], 1);
        check("t2_err", ec[1], 0);

        repeat (4) @(negedge clock);
        run_seq(2, 8, 16, 2, -1, -1, c);
        cnt = 0;
        first = -1;
        e = 0;
        g = 0;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] ex, gt;
            ex = stim(i, 8);
            gt = (i == 0) ? 16'h0 : stim(i - 1, 8);
            if (ex != gt) begin
                cnt++;
                if (first < 0) begin
                    first = i;
                    e = ex;
                    g = gt;
                end
            end
        end
        check("t2b_busy_cycles", c, 18);
        check("t2b_err", ec[2], cnt);
        check("t2b_pass", ps[2], (cnt == 0));
        check("t2b_done", dn[2], 1);
        check_cap("t2b_cap", 2, (first < 0) ? 16'h0 : 16'(first), e, g);

        // Test 3: bit0 stuck at 1
        run_seq(3, 1, 16, 0, -1, -1, c);
        cnt = 0;
        first = -1;
        for (int i = 0; i < 16; i++) begin
            if (stim(i, 1) == 16'h0) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        check("t3_err", ec[3], cnt);
        check("t3_pass", ps[3], (cnt == 0));
        check_cap("t3_cap", 3, (first < 0) ? 16'h0 : 16'(first), 0, (first < 0) ? 16'h0 : 16'h1);

        // Test 4: inverter, counter saturation
        run_seq(4, 4, 300, 0, -1, -1, c);
        check("t4_busy_cycles", c, 300);
        check("t4_err_sat", ec[4], 255);
        check("t4_pass", ps[4], 0);
        check("t4_done", dn[4], 1);
        e = stim(0, 4);
        check_cap("t4_cap", 4, 0, e, (~e) & 16'hF);

        // Test 5: abort on the 5th drive cycle, then a clean rerun
        run_seq(0, 8, 16, 0, 4, -1, c);
        check("t5_busy_cycles", c, 5);
        check("t5_busy", bz[0], 0);
        check("t5_done", dn[0], 0);
        check("t5_pass", ps[0], 0);
        check("t5_err", ec[0], 0);
        repeat (2) @(negedge clock);
        run_seq(0, 8, 16, 0, -1, -1, c);
        check("t5b_busy_cycles", c, 16);
        check("t5b_pass", ps[0], 1);

        // Test 6: asynchronous reset during DRAIN
        repeat (4) @(negedge clock);
        st[1] = 1'b1;
        @(negedge clock);
        st[1] = 1'b0;
        repeat (17) @(negedge clock);
        check("t6_busy_pre", bz[1], 1);
        #2 reset = 1'b1;
        #1;
        check("t6_busy", bz[1], 0);
        check("t6_done", dn[1], 0);
        check("t6_pass", ps[1], 0);
        check("t6_err", ec[1], 0);
        check("t6_din", din_w[1], 0);
        check_cap("t6_cap", 1, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        run_seq(1, 8, 16, 3, -1, -1, c);
        check("t6b_busy_cycles", c, 19);
        check("t6b_pass", ps[1], 1);

        // Randomized runs: random bit flips at the DUT input, some aborted
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 64; k++) begin
                flips[k] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'h0;
            end
            abort_at = (r % 2 == 1) ? int'($urandom_range(0, 43)) : -1;
            repeat (4) @(negedge clock);
            run_seq(5, 5, 40, 4, abort_at, -1, c);
            // a vector's compare lands 4 cycles after its drive cycle
            limit = (abort_at < 0) ? 40 : abort_at - 4;
            cnt = 0;
            first = -1;
            for (int i = 0; i < 40; i++) begin
                if (i < limit && flips[i] != 5'h0) begin
                    cnt++;
                    if (first < 0) first = i;
                end
            end
            check("rnd_busy_cycles", c, (abort_at < 0) ? 44 : abort_at + 1);
            check("rnd_err", ec[5], cnt);
            check("rnd_done", dn[5], (abort_at < 0));
            check("rnd_pass", ps[5], (abort_at < 0) && (cnt == 0));
            if (first >= 0) begin
                e = stim(first, 5);
                check_cap("rnd_cap", 5, 16'(first), e, e ^ {11'h0, flips[first]});
            end else begin
                check_cap("rnd_cap", 5, 0, 0, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
